// File: rtl/mult_feeder_pkg.sv
// Shared types and default sizing for the multiplier operand feeder.
package mult_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } feeder_state_t;

    localparam int DEFAULT_WIDTH = 5;
    localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/op_fifo.sv
// Synchronous operand FIFO with a combinational head and an occupancy count.
module op_fifo #(
    parameter  int DW    = 10,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    // Requests against a full or empty FIFO are dropped so the count never wraps.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mult_operand_feeder.sv
// Operand-issue stage: buffers (a,b) pairs, issues them one at a time to the
// multiplier and holds each product in a valid/ready output register.
module mult_operand_feeder
    import mult_feeder_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               req,
    input  logic               rdy,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    input  logic               done,
    input  logic [2*WIDTH-1:0] ab,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_ab,
    output logic [CW-1:0]      count,
    output logic               err,
    output feeder_state_t      state
);

    // Handshakes: a transfer happens on the rising edge where valid (or req) and
    // ready (or rdy) are both high; the offering side holds its data until then.

    feeder_state_t      r_state;
    feeder_state_t      w_next_state;
    logic               w_load;
    logic               r_req;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_out_valid;
    logic [2*WIDTH-1:0] r_out_ab;
    logic               r_err;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    logic [2*WIDTH-1:0] w_rdata;
    logic [WIDTH-1:0]   w_head_a;
    logic [WIDTH-1:0]   w_head_b;
    logic               w_pending;

    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign w_pop    = (r_state == ISSUE) && r_req && rdy;

    op_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({in_a, in_b}),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Leaving HOLD into an empty FIFO that is being written this edge: the
    // entry is not in the memory yet, so take it straight from the input.
    assign w_head_a  = w_empty ? in_a : w_rdata[2*WIDTH-1:WIDTH];
    assign w_head_b  = w_empty ? in_b : w_rdata[WIDTH-1:0];
    assign w_pending = (w_count != '0) || w_push;

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if ((w_count != '0) && !r_out_valid) begin
                    w_next_state = ISSUE;
                    w_load       = 1'b1;
                end
            end
            ISSUE: begin
                if (r_req && rdy) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (done) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_next_state = w_pending ? ISSUE : IDLE;
                    w_load       = w_pending;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_out_valid <= 1'b0;
            r_out_ab    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_req   <= (w_next_state == ISSUE);
            if (w_load) begin
                r_a <= w_head_a;
                r_b <= w_head_b;
            end
            if ((r_state == WAIT) && done) begin
                r_out_ab    <= ab;
                r_out_valid <= 1'b1;
            end else if ((r_state == HOLD) && out_ready) begin
                r_out_valid <= 1'b0;
            end
            // A strobe outside WAIT has no operation to belong to.
            if (done && (r_state != WAIT)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign req       = r_req;
    assign a         = r_a;
    assign b         = r_b;
    assign out_valid = r_out_valid;
    assign out_ab    = r_out_ab;
    assign count     = w_count;
    assign err       = r_err;
    assign state     = r_state;

endmodule

// File: tb/tb_mult_operand_feeder.sv
// Bench for mult_operand_feeder: behavioural multiplier, random consumer,
// scoreboard of expected products in issue order.
module tb_mult_operand_feeder;
  import mult_feeder_pkg::*;

  localparam int W  = 5;
  localparam int D  = 4;
  localparam int PW = 2 * W;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          req;
  logic          rdy;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          done;
  logic [PW-1:0] ab;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_ab;
  logic [CW-1:0] count;
  logic          err;
  feeder_state_t state;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] last_prod;
  int            n_checks = 0;
  int            n_fail = 0;
  logic          rdy_en;
  int            lat_min;
  int            lat_max;
  int            ready_mode;
  logic          inject_req;
  logic          inject_ack;

  mult_operand_feeder #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .req       (req),
    .rdy       (rdy),
    .a         (a),
    .b         (b),
    .done      (done),
    .ab        (ab),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ab    (out_ab),
    .count     (count),
    .err       (err),
    .state     (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout, required event within cycle budget", name);
  endtask

  // ---------------- multiplier model ----------------
  initial begin : mult_model
    logic [PW-1:0] prod;
    int            lat;
    bit            killed;
    rdy = 1'b1;
    done = 1'b0;
    ab = '0;
    inject_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && req && rdy) begin
        prod = PW'(a) * PW'(b);
        lat = $urandom_range(lat_max, lat_min);
        killed = 1'b0;
        @(posedge clk);
        #1 rdy = 1'b0;
        repeat (lat) begin
          @(posedge clk);
          #1;
          if (rst) killed = 1'b1;
        end
        if (!killed && !rst) begin
          done = 1'b1;
          ab = prod;
          @(posedge clk);
          #1 done = 1'b0;
        end
        rdy = rdy_en;
      end else begin
        @(posedge clk);
        #1 rdy = rdy_en;
        if (inject_req && !inject_ack) begin
          done = 1'b1;
          ab = 10'h155;
          @(posedge clk);
          #1 done = 1'b0;
          inject_ack = 1'b1;
        end
      end
    end
  end

  // ---------------- consumer ----------------
  initial begin : consumer
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [PW-1:0] exp_v;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got out_ab=%0d, required no result", out_ab);
        end else begin
          exp_v = exp_q.pop_front();
          check("result_order", 32'(out_ab), 32'(exp_v));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic push_pair(input logic [W-1:0] pa, input logic [W-1:0] pb);
    int t = 0;
    in_valid = 1'b1;
    in_a = pa;
    in_b = pb;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        last_prod = PW'(pa) * PW'(pb);
        exp_q.push_back(last_prod);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      t++;
      if (t > 500) begin
        timeout_fail("push_timeout");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (!(exp_q.size() == 0 && count == '0 && state == IDLE && !out_valid)) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 2000) begin
        timeout_fail(name);
        break;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},       32'(req),       32'd0);
    check({tag, "_a"},         32'(a),         32'd0);
    check({tag, "_b"},         32'(b),         32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_ab"},    32'(out_ab),    32'd0);
    check({tag, "_count"},     32'(count),     32'd0);
    check({tag, "_err"},       32'(err),       32'd0);
    check({tag, "_state"},     32'(state),     32'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int t;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    rdy_en = 1'b1;
    lat_min = 0;
    lat_max = 2;
    ready_mode = 0;
    inject_req = 1'b0;
    last_prod = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1: single pair, req one cycle after push, a/b presented
    push_pair(5'd3, 5'd7);
    @(negedge clk);
    check("t1_req_not_yet", 32'(req), 32'd0);
    check("t1_count", 32'(count), 32'd1);
    @(negedge clk);
    check("t1_req_high", 32'(req), 32'd1);
    check("t1_a", 32'(a), 32'd3);
    check("t1_b", 32'(b), 32'd7);
    @(posedge clk);
    #1;
    wait_drain("t1_drain");
    check("t1_count_zero", 32'(count), 32'd0);

    // 2: extremes
    push_pair(5'd31, 5'd31);
    push_pair(5'd0, 5'd25);
    wait_drain("t2_drain");

    // 3: multiplier stalled, FIFO fills
    rdy_en = 1'b0;
    cycles(3);
    push_pair(5'd1, 5'd2);
    push_pair(5'd3, 5'd4);
    push_pair(5'd5, 5'd6);
    push_pair(5'd7, 5'd8);
    fork
      push_pair(5'd9, 5'd10);
      begin
        @(negedge clk);
        check("t3_count_full", 32'(count), 32'd4);
        check("t3_in_ready", 32'(in_ready), 32'd0);
        check("t3_req_held", 32'(req), 32'd1);
        check("t3_a_held", 32'(a), 32'd1);
        @(negedge clk);
        check("t3_still_full", 32'(count), 32'd4);
        @(posedge clk);
        #1 rdy_en = 1'b1;
      end
    join
    wait_drain("t3_drain");

    // 4: consumer stalled, result held and issue paused
    ready_mode = 1;
    cycles(2);
    push_pair(5'd2, 5'd3);
    push_pair(5'd4, 5'd5);
    push_pair(5'd6, 5'd7);
    t = 0;
    while (!out_valid && t < 200) begin
      cycles(1);
      t++;
    end
    if (!out_valid) timeout_fail("t4_wait_valid");
    cycles(4);
    @(negedge clk);
    check("t4_held_ab", 32'(out_ab), 32'd6);
    check("t4_held_valid", 32'(out_valid), 32'd1);
    check("t4_req_low", 32'(req), 32'd0);
    check("t4_count", 32'(count), 32'd2);
    @(posedge clk);
    #1 ready_mode = 0;
    wait_drain("t4_drain");
    check("t4_err_clear", 32'(err), 32'd0);

    // 5: stray done while idle
    inject_req = 1'b1;
    t = 0;
    while (!inject_ack && t < 50) begin
      cycles(1);
      t++;
    end
    if (!inject_ack) timeout_fail("t5_inject");
    inject_req = 1'b0;
    @(negedge clk);
    check("t5_err", 32'(err), 32'd1);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_out_ab_kept", 32'(out_ab), 32'(last_prod));
    check("t5_state", 32'(state), 32'(IDLE));
    @(posedge clk);
    #1;

    // 6: reset while a multiply is in flight
    lat_min = 6;
    lat_max = 6;
    push_pair(5'd11, 5'd12);
    push_pair(5'd13, 5'd14);
    push_pair(5'd15, 5'd16);
    t = 0;
    forever begin
      @(negedge clk);
      if (state == WAIT || t > 50) break;
      t++;
    end
    if (state != WAIT) timeout_fail("t6_wait_state");
    check("t6_count", 32'(count), 32'd2);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_reset_values("t6_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lat_min = 0;
    lat_max = 3;
    cycles(2);
    push_pair(5'd1, 5'd1);
    wait_drain("t6_drain");
    check("t6_err_after", 32'(err), 32'd0);

    // random traffic
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      cycles($urandom_range(0, 2));
      push_pair(W'($urandom_range(0, 31)), W'($urandom_range(0, 31)));
    end
    wait_drain("rand_drain");
    check("rand_err", 32'(err), 32'd0);
    check("rand_count", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
